// File: rtl/ww_pose_sequencer_if.sv
// Control and result bundle between the keycode decoder and one WW fighter's
// pose sequencer. The master side drives button levels and the frame tick;
// the slave side (the sequencer) returns the pose select and its side outputs.
interface ww_pose_sequencer_if;
  logic       frame_tick;
  logic       punch_req;
  logic       kick_req;
  logic       jump_req;
  logic       block_hold;
  logic       crouch_hold;
  logic       dead;
  logic [3:0] pose;
  logic       attack_active;
  logic       busy;
  logic [7:0] y_offset;

  modport master (
    output frame_tick, punch_req, kick_req, jump_req, block_hold, crouch_hold, dead,
    input  pose, attack_active, busy, y_offset
  );

  modport slave (
    input  frame_tick, punch_req, kick_req, jump_req, block_hold, crouch_hold, dead,
    output pose, attack_active, busy, y_offset
  );
endinterface

// File: rtl/ww_pose_sequencer.sv
// Per-fighter pose controller for the WW character. Turns button levels and
// the per-frame tick into a registered sprite/palette pose select, plus the
// attack hit-window flag and the upward jump displacement.
module ww_pose_sequencer #(
  parameter int unsigned IDLE_FRAMES  = 16,
  parameter int unsigned PUNCH_FRAMES = 12,
  parameter int unsigned KICK_FRAMES  = 16,
  parameter int unsigned JUMP_FRAMES  = 32,
  parameter int unsigned JUMP_STEP    = 4,
  parameter int unsigned HIT_LO       = 4,
  parameter int unsigned HIT_HI       = 8
) (
  input  logic Clk,
  input  logic Reset,
  ww_pose_sequencer_if.slave bus
);

  // Pose select encoding shared with the sprite ROM / palette muxes.
  localparam logic [3:0] POSE_STAND       = 4'd0;
  localparam logic [3:0] POSE_STAND2      = 4'd1;
  localparam logic [3:0] POSE_BLOCK       = 4'd2;
  localparam logic [3:0] POSE_CROUCH      = 4'd3;
  localparam logic [3:0] POSE_CROUCHPUNCH = 4'd4;
  localparam logic [3:0] POSE_DEAD        = 4'd5;
  localparam logic [3:0] POSE_JUMP        = 4'd6;
  localparam logic [3:0] POSE_KICK        = 4'd7;
  localparam logic [3:0] POSE_PUNCH       = 4'd8;

  // Last frame_cnt value of each timed action; the exit happens on the tick
  // that arrives while the counter sits here.
  localparam logic [5:0] IDLE_LAST  = 6'(IDLE_FRAMES - 1);
  localparam logic [5:0] PUNCH_LAST = 6'(PUNCH_FRAMES - 1);
  localparam logic [5:0] KICK_LAST  = 6'(KICK_FRAMES - 1);
  localparam logic [5:0] JUMP_LAST  = 6'(JUMP_FRAMES - 1);
  localparam logic [5:0] JUMP_HALF  = 6'(JUMP_FRAMES / 2);
  localparam logic [5:0] HIT_FIRST  = 6'(HIT_LO);
  localparam logic [5:0] HIT_LAST   = 6'(HIT_HI);
  localparam logic [7:0] STEP_8     = 8'(JUMP_STEP);
  localparam logic [7:0] JUMP_LEN_8 = 8'(JUMP_FRAMES);

  // Button index within the edge-detected press vector.
  localparam int BTN_PUNCH = 0;
  localparam int BTN_KICK  = 1;
  localparam int BTN_JUMP  = 2;

  typedef enum logic [2:0] {
    IDLE,
    BLOCK,
    CROUCH,
    CROUCHPUNCH,
    PUNCH,
    KICK,
    JUMP,
    DEAD
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] frame_cnt_reg, frame_cnt_next;
  logic [5:0] idle_cnt_reg, idle_cnt_next;
  logic       phase_reg, phase_next;

  logic [2:0] btn;
  logic [2:0] btn_q_reg;
  logic [2:0] btn_e;

  logic [5:0] timed_last;
  logic       timed_state;
  logic       timed_done;

  logic [3:0] pose_next;
  logic       attack_next;
  logic       busy_next;
  logic [7:0] y_next;

  assign btn[BTN_PUNCH] = bus.punch_req;
  assign btn[BTN_KICK]  = bus.kick_req;
  assign btn[BTN_JUMP]  = bus.jump_req;

  // Rising-edge detect per action button. The delayed copies come out of
  // reset high, so a button held through reset never fires by itself.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign btn_e[gi] = btn[gi] & ~btn_q_reg[gi];
    end
  endgenerate

  // Duration of the current timed action and whether this tick ends it.
  always_comb begin
    timed_last  = 6'd0;
    timed_state = 1'b0;
    case (state_reg)
      PUNCH:       begin timed_last = PUNCH_LAST; timed_state = 1'b1; end
      CROUCHPUNCH: begin timed_last = PUNCH_LAST; timed_state = 1'b1; end
      KICK:        begin timed_last = KICK_LAST;  timed_state = 1'b1; end
      JUMP:        begin timed_last = JUMP_LAST;  timed_state = 1'b1; end
      default:     begin timed_last = 6'd0;       timed_state = 1'b0; end
    endcase
    timed_done = timed_state & bus.frame_tick & (frame_cnt_reg == timed_last);
  end

  // Next-state selection; dead overrides everything, and presses that the
  // current state cannot use are simply lost.
  always_comb begin
    state_next = state_reg;
    if (bus.dead) begin
      state_next = DEAD;
    end else begin
      case (state_reg)
        IDLE: begin
          if (btn_e[BTN_JUMP])       state_next = JUMP;
          else if (btn_e[BTN_KICK])  state_next = KICK;
          else if (btn_e[BTN_PUNCH]) state_next = PUNCH;
          else if (bus.block_hold)   state_next = BLOCK;
          else if (bus.crouch_hold)  state_next = CROUCH;
        end
        BLOCK: begin
          if (!bus.block_hold) state_next = bus.crouch_hold ? CROUCH : IDLE;
        end
        CROUCH: begin
          if (bus.block_hold)          state_next = BLOCK;
          else if (btn_e[BTN_PUNCH])   state_next = CROUCHPUNCH;
          else if (!bus.crouch_hold)   state_next = IDLE;
        end
        CROUCHPUNCH: begin
          if (timed_done) state_next = bus.crouch_hold ? CROUCH : IDLE;
        end
        PUNCH, KICK, JUMP: begin
          if (timed_done) state_next = IDLE;
        end
        DEAD:    state_next = DEAD;
        default: state_next = IDLE;
      endcase
    end
  end

  // Action frame counter plus the idle stand/stand2 animation counter.
  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    idle_cnt_next  = idle_cnt_reg;
    phase_next     = phase_reg;

    // The action counter restarts on every state change and only runs in
    // timed states, so entering an action always begins at frame 0.
    if ((state_next != state_reg) || !timed_state) begin
      frame_cnt_next = 6'd0;
    end else if (bus.frame_tick) begin
      frame_cnt_next = frame_cnt_reg + 6'd1;
    end

    // Idle animation only runs while we stay in IDLE; any excursion resets
    // both the count and the phase so returning to IDLE shows stand first.
    if ((state_reg == IDLE) && (state_next == IDLE)) begin
      if (bus.frame_tick) begin
        if (idle_cnt_reg == IDLE_LAST) begin
          idle_cnt_next = 6'd0;
          phase_next    = ~phase_reg;
        end else begin
          idle_cnt_next = idle_cnt_reg + 6'd1;
        end
      end
    end else begin
      idle_cnt_next = 6'd0;
      phase_next    = 1'b0;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state register on the same edge.
  always_comb begin
    pose_next   = POSE_STAND;
    attack_next = 1'b0;
    busy_next   = 1'b0;
    y_next      = 8'd0;
    case (state_next)
      IDLE:        pose_next = phase_next ? POSE_STAND2 : POSE_STAND;
      BLOCK:       pose_next = POSE_BLOCK;
      CROUCH:      pose_next = POSE_CROUCH;
      CROUCHPUNCH: pose_next = POSE_CROUCHPUNCH;
      PUNCH:       pose_next = POSE_PUNCH;
      KICK:        pose_next = POSE_KICK;
      JUMP:        pose_next = POSE_JUMP;
      DEAD:        pose_next = POSE_DEAD;
      default:     pose_next = POSE_STAND;
    endcase

    if ((state_next == PUNCH) || (state_next == KICK) ||
        (state_next == CROUCHPUNCH) || (state_next == JUMP)) begin
      busy_next = 1'b1;
    end

    if (((state_next == PUNCH) || (state_next == KICK) || (state_next == CROUCHPUNCH)) &&
        (frame_cnt_next >= HIT_FIRST) && (frame_cnt_next <= HIT_LAST)) begin
      attack_next = 1'b1;
    end

    // Symmetric rise/fall profile peaking at the half-way frame.
    if (state_next == JUMP) begin
      if (frame_cnt_next < JUMP_HALF) begin
        y_next = {2'b00, frame_cnt_next} * STEP_8;
      end else begin
        y_next = (JUMP_LEN_8 - {2'b00, frame_cnt_next}) * STEP_8;
      end
    end
  end

  // State, counters, button history and all outputs registered together.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg         <= IDLE;
      frame_cnt_reg     <= 6'd0;
      idle_cnt_reg      <= 6'd0;
      phase_reg         <= 1'b0;
      btn_q_reg         <= 3'b111;
      bus.pose          <= POSE_STAND;
      bus.attack_active <= 1'b0;
      bus.busy          <= 1'b0;
      bus.y_offset      <= 8'd0;
    end else begin
      state_reg         <= state_next;
      frame_cnt_reg     <= frame_cnt_next;
      idle_cnt_reg      <= idle_cnt_next;
      phase_reg         <= phase_next;
      btn_q_reg         <= btn;
      bus.pose          <= pose_next;
      bus.attack_active <= attack_next;
      bus.busy          <= busy_next;
      bus.y_offset      <= y_next;
    end
  end

endmodule

// File: tb/tb_ww_pose_sequencer.sv
// Self-checking bench for ww_pose_sequencer: a vector table for the state
// transition corners plus hand-written loops for the multi-tick actions.
// Expected results are queued when a cycle is driven and checked after it.
module tb_ww_pose_sequencer;

  logic clk;
  logic rst_n;

  ww_pose_sequencer_if bus ();

  ww_pose_sequencer dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       p, k, j, b, c, d, t;
    logic [3:0] pose;
    logic       att;
    logic       busy;
    logic [7:0] y;
    string      name;
  } vec_t;

  typedef struct packed {
    logic [3:0] pose;
    logic       att;
    logic       busy;
    logic [7:0] y;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  function automatic vec_t mk(input logic rstn, input logic p, input logic k, input logic j,
                              input logic b, input logic c, input logic d, input logic t,
                              input logic [3:0] pose, input logic att, input logic busy,
                              input logic [7:0] y, input string name);
    vec_t v;
    v.rstn = rstn; v.p = p; v.k = k; v.j = j; v.b = b; v.c = c; v.d = d; v.t = t;
    v.pose = pose; v.att = att; v.busy = busy; v.y = y; v.name = name;
    return v;
  endfunction

  // Compare the oldest queued expectation against what the DUT now shows.
  task automatic check_front();
    exp_t  e;
    string n;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_empty: got nothing queued, required an expectation");
      return;
    end
    e = exp_q.pop_front();
    n = name_q.pop_front();
    tests_run++;
    if (bus.pose !== e.pose || bus.attack_active !== e.att ||
        bus.busy !== e.busy || bus.y_offset !== e.y) begin
      tests_failed++;
      $display("FAIL %s: got pose=%0d att=%0b busy=%0b y=%0d, required pose=%0d att=%0b busy=%0b y=%0d",
               n, bus.pose, bus.attack_active, bus.busy, bus.y_offset,
               e.pose, e.att, e.busy, e.y);
    end else begin
      $display("[TB] ok %s: pose=%0d att=%0b busy=%0b y=%0d",
               n, bus.pose, bus.attack_active, bus.busy, bus.y_offset);
    end
  endtask

  // Drive one clock cycle of inputs, queue its expectation, check after edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rst_n           = v.rstn;
    bus.punch_req   = v.p;
    bus.kick_req    = v.k;
    bus.jump_req    = v.j;
    bus.block_hold  = v.b;
    bus.crouch_hold = v.c;
    bus.dead        = v.d;
    bus.frame_tick  = v.t;
    e.pose = v.pose; e.att = v.att; e.busy = v.busy; e.y = v.y;
    exp_q.push_back(e);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic step(input logic p, input logic k, input logic j, input logic b,
                      input logic c, input logic d, input logic t,
                      input logic [3:0] pose, input logic att, input logic busy,
                      input logic [7:0] y, input string name);
    apply(mk(1'b1, p, k, j, b, c, d, t, pose, att, busy, y, name));
  endtask

  vec_t vecs[27];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rstn p  k  j  b  c  d  t   pose att busy y
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "reset_a");
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "reset_b");
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "idle_after_reset");
    vecs[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0,  2, 0, 0, 0, "block_and_crouch");
    vecs[4]  = mk(1, 0, 1, 0, 1, 1, 0, 0,  2, 0, 0, 0, "kick_in_block_ignored");
    vecs[5]  = mk(1, 0, 1, 1, 1, 1, 0, 0,  2, 0, 0, 0, "jump_in_block_ignored");
    vecs[6]  = mk(1, 0, 1, 1, 0, 1, 0, 0,  3, 0, 0, 0, "drop_block_to_crouch");
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "drop_crouch_to_idle");
    vecs[8]  = mk(1, 0, 1, 0, 0, 0, 0, 0,  7, 0, 1, 0, "kick_start");
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1,  7, 0, 1, 0, "kick_t1");
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 1,  7, 0, 1, 0, "kick_t2");
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 1,  7, 0, 1, 0, "kick_t3");
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 1,  7, 1, 1, 0, "kick_t4_hit");
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 1,  7, 1, 1, 0, "kick_t5_hit");
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 1, 1,  5, 0, 0, 0, "dead_mid_kick");
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, "dead_absorbing");
    vecs[16] = mk(1, 1, 0, 0, 0, 0, 0, 1,  5, 0, 0, 0, "dead_ignores_punch");
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, "dead_still");
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "reset_from_dead");
    vecs[19] = mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "punch_held_through_reset");
    vecs[20] = mk(1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, "punch_still_held");
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "punch_released");
    vecs[22] = mk(1, 1, 0, 0, 0, 0, 0, 0,  8, 0, 1, 0, "punch_repressed");
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0,  8, 0, 1, 0, "punch_running");
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, "reset_mid_punch");
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "reset_hold");
    vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "idle_clean");

    rst_n = 1'b0;
    bus.frame_tick = 0; bus.punch_req = 0; bus.kick_req = 0; bus.jump_req = 0;
    bus.block_hold = 0; bus.crouch_hold = 0; bus.dead = 0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Idle animation: stand for 16 ticks, stand2 for 16, then stand again.
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 4'((i / 16) % 2), 0, 0, 0, $sformatf("idle_tick%0d", i));
    end

    // Punch: hit window on frames 4..8, re-press at tick 5 and at the exit
    // tick are both dropped.
    step(1, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, "punch_start");
    for (int k = 1; k <= 12; k++) begin
      if (k < 12)
        step(logic'(k == 5), 0, 0, 0, 0, 0, 1, 8, logic'(k >= 4 && k <= 8), 1, 0,
             $sformatf("punch_tick%0d", k));
      else
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "punch_exit_with_press");
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "exit_press_dropped");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "punch_release");

    // Jump: triangle height profile, never an attack.
    step(0, 0, 1, 0, 0, 0, 0, 6, 0, 1, 0, "jump_start");
    for (int k = 1; k <= 32; k++) begin
      if (k < 32)
        step(0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 8'(k < 16 ? 4 * k : 4 * (32 - k)),
             $sformatf("jump_tick%0d", k));
      else
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "jump_exit");
    end

    // Crouch punch returning to crouch while crouch stays held.
    step(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, "crouch");
    step(1, 0, 0, 0, 1, 0, 0, 4, 0, 1, 0, "crouchpunch_start");
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0, 1, 0, 1, (k < 12) ? 4'd4 : 4'd3, logic'(k >= 4 && k <= 8),
           logic'(k < 12), 0, $sformatf("cpunch_held_tick%0d", k));
    end

    // Same again, but crouch released during the action: exit to idle.
    step(1, 0, 0, 0, 1, 0, 0, 4, 0, 1, 0, "crouchpunch2_start");
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0, logic'(k < 3), 0, 1, (k < 12) ? 4'd4 : 4'd0,
           logic'(k >= 4 && k <= 8), logic'(k < 12), 0, $sformatf("cpunch_rel_tick%0d", k));
    end

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
